// File: rtl/cpu_leds_blink_if.sv
// Avalon-MM slave bus for the LED PIO: register address, select, write strobe, write data
// and combinational read data.
interface cpu_leds_blink_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/cpu_leds_blink.sv
// Avalon-MM LED output PIO with atomic SET/CLEAR/TOGGLE writes and a per-bit blink engine.
// Define CPU_LEDS_BLINK_IRQ_EN to add the phase-toggle interrupt (irq port, STATUS bit1, CONTROL bit0).
module cpu_leds_blink #(
  parameter int unsigned     WIDTH       = 14,
  parameter int unsigned     PRESCALE_W  = 24,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  cpu_leds_blink_if.slave  bus,
`ifdef CPU_LEDS_BLINK_IRQ_EN
  output logic             irq,
`endif
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] A_DATA    = 3'd0;
  localparam logic [2:0] A_SET     = 3'd1;
  localparam logic [2:0] A_CLEAR   = 3'd2;
  localparam logic [2:0] A_TOGGLE  = 3'd3;
  localparam logic [2:0] A_MASK    = 3'd4;
  localparam logic [2:0] A_PERIOD  = 3'd5;
  localparam logic [2:0] A_STATUS  = 3'd6;
  localparam logic [2:0] A_CONTROL = 3'd7;

  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_mask;
  logic [PRESCALE_W-1:0] r_period;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_phase;

  logic             w_wr;
  logic [WIDTH-1:0] w_wd;
  logic             w_restart;
  logic             w_tc;
  logic             w_irq_pend;
  logic             w_irq_en;
  logic             w_unused_wd;

  assign w_wr        = bus.chipselect & ~bus.write_n;
  assign w_wd        = bus.writedata[WIDTH-1:0];
  assign w_unused_wd = ^bus.writedata;

  // A PERIOD write or CONTROL.restart beats a coincident terminal count.
  assign w_restart = w_wr & ((bus.address == A_PERIOD) |
                             ((bus.address == A_CONTROL) & bus.writedata[1]));
  assign w_tc      = (r_period != '0) & (r_cnt == r_period - PRESCALE_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data   <= RESET_VALUE;
      r_mask   <= '0;
      r_period <= '0;
    end else if (w_wr) begin
      case (bus.address)
        A_DATA:   r_data   <= w_wd;
        A_SET:    r_data   <= r_data | w_wd;
        A_CLEAR:  r_data   <= r_data & ~w_wd;
        A_TOGGLE: r_data   <= r_data ^ w_wd;
        A_MASK:   r_mask   <= w_wd;
        A_PERIOD: r_period <= bus.writedata[PRESCALE_W-1:0];
        default:  ;
      endcase
    end
  end

  // Blink prescaler: cnt wraps at PERIOD-1 and flips the phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_restart || (r_period == '0)) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (w_tc) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt   <= r_cnt + PRESCALE_W'(1);
    end
  end

`ifdef CPU_LEDS_BLINK_IRQ_EN
  logic r_irq_pend;
  logic r_irq_en;

  // Set wins over a coincident clear so no toggle event is lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irq_pend <= 1'b0;
      r_irq_en   <= 1'b0;
    end else begin
      if (w_tc && !w_restart)
        r_irq_pend <= 1'b1;
      else if (w_wr && (bus.address == A_STATUS) && bus.writedata[1])
        r_irq_pend <= 1'b0;
      if (w_wr && (bus.address == A_CONTROL))
        r_irq_en <= bus.writedata[0];
    end
  end

  assign w_irq_pend = r_irq_pend;
  assign w_irq_en   = r_irq_en;
  assign irq        = r_irq_pend & r_irq_en;
`else
  assign w_irq_pend = 1'b0;
  assign w_irq_en   = 1'b0;
`endif

  assign out_port = r_data ^ (r_mask & {WIDTH{r_phase}});

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      A_DATA, A_SET, A_CLEAR, A_TOGGLE: bus.readdata = 32'(r_data);
      A_MASK:    bus.readdata = 32'(r_mask);
      A_PERIOD:  bus.readdata = 32'(r_period);
      A_STATUS:  bus.readdata = {30'd0, w_irq_pend, r_phase};
      A_CONTROL: bus.readdata = {31'd0, w_irq_en};
      default:   bus.readdata = '0;
    endcase
  end

endmodule
